// File: rtl/svc_soc_io_init.sv
// MMIO initiator: turns a valid/ready command stream into single-beat I/O register
// bus reads/writes and returns one response per command, with configurable read latency.
module svc_soc_io_init #(
  parameter int RD_LATENCY = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_data,
  input  logic [3:0]  cmd_strb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_write,
  output logic        rsp_err,
  output logic [31:0] rsp_data,
  output logic        io_wen,
  output logic [31:0] io_waddr,
  output logic [31:0] io_wdata,
  output logic [3:0]  io_wstrb,
  output logic        io_ren,
  output logic [31:0] io_raddr,
  input  logic [31:0] io_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        io_wen_q, io_wen_d;
  logic        io_ren_q, io_ren_d;
  logic [31:0] io_waddr_q, io_waddr_d;
  logic [31:0] io_wdata_q, io_wdata_d;
  logic [3:0]  io_wstrb_q, io_wstrb_d;
  logic [31:0] io_raddr_q, io_raddr_d;
  logic        rsp_write_q, rsp_write_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_data_q, rsp_data_d;

  always_comb begin
    // NOTE: every next-state variable gets a default first, so no path leaves one unassigned and infers a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    io_wen_d    = 1'b0;
    io_ren_d    = 1'b0;
    io_waddr_d  = io_waddr_q;
    io_wdata_d  = io_wdata_q;
    io_wstrb_d  = io_wstrb_q;
    io_raddr_d  = io_raddr_q;
    rsp_write_d = rsp_write_q;
    rsp_err_d   = rsp_err_q;
    rsp_data_d  = rsp_data_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_addr[1:0] != 2'b00) begin
            // Misaligned: answer directly without touching the bus.
            rsp_err_d   = 1'b1;
            rsp_data_d  = '0;
            rsp_write_d = cmd_write;
            state_d     = S_RESP;
          end else if (cmd_write) begin
            io_waddr_d = cmd_addr;
            io_wdata_d = cmd_data;
            io_wstrb_d = cmd_strb;
            io_wen_d   = 1'b1;
            state_d    = S_WR;
          end else begin
            io_raddr_d = cmd_addr;
            io_ren_d   = 1'b1;
            cnt_d      = 2'(RD_LATENCY);
            state_d    = S_RD;
          end
        end
      end
      S_WR: begin
        rsp_write_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_data_d  = '0;
        state_d     = S_RESP;
      end
      S_RD: begin
        if (cnt_q == 2'd0) begin
          rsp_data_d  = io_rdata;
          rsp_write_d = 1'b0;
          rsp_err_d   = 1'b0;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      io_wen_q    <= 1'b0;
      io_ren_q    <= 1'b0;
      io_waddr_q  <= '0;
      io_wdata_q  <= '0;
      io_wstrb_q  <= '0;
      io_raddr_q  <= '0;
      rsp_write_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      io_wen_q    <= io_wen_d;
      io_ren_q    <= io_ren_d;
      io_waddr_q  <= io_waddr_d;
      io_wdata_q  <= io_wdata_d;
      io_wstrb_q  <= io_wstrb_d;
      io_raddr_q  <= io_raddr_d;
      rsp_write_q <= rsp_write_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Ready is masked by rst so no command can be taken while reset is held.
  assign cmd_ready = (state_q == S_IDLE) && !rst;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_write = rsp_write_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_data  = rsp_data_q;
  assign io_wen    = io_wen_q;
  assign io_waddr  = io_waddr_q;
  assign io_wdata  = io_wdata_q;
  assign io_wstrb  = io_wstrb_q;
  assign io_ren    = io_ren_q;
  assign io_raddr  = io_raddr_q;

endmodule

// File: tb/tb_svc_soc_io_init.sv
// Scoreboard bench for svc_soc_io_init: a driver pushes expected bus beats and responses,
// monitors pop and compare; a register-bank model answers reads after LAT cycles.
module tb_svc_soc_io_init;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_data = '0;
  logic [3:0]  cmd_strb = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_write, rsp_err;
  logic [31:0] rsp_data;
  logic        io_wen, io_ren;
  logic [31:0] io_waddr, io_wdata, io_raddr, io_rdata = '0;
  logic [3:0]  io_wstrb;

  svc_soc_io_init #(.RD_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_err(rsp_err), .rsp_data(rsp_data),
    .io_wen(io_wen), .io_waddr(io_waddr), .io_wdata(io_wdata), .io_wstrb(io_wstrb),
    .io_ren(io_ren), .io_raddr(io_raddr), .io_rdata(io_rdata)
  );

  always #5 clk = ~clk;

  typedef struct { logic w; logic err; logic [31:0] data; int exp_cyc; } rsp_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; logic [3:0] strb; int exp_cyc; } wr_t;
  typedef struct { logic [31:0] addr; int exp_cyc; } rd_t;

  rsp_t rsp_q[$];
  wr_t  wr_q[$];
  rd_t  rd_q[$];

  logic [31:0] ref_mem  [logic [31:0]];
  logic [31:0] bank_mem [logic [31:0]];

  int total = 0, bad = 0;
  int cyc = 0;
  int acc_cyc = 0, hs_cyc = 0;
  logic rdy_force = 1'b1, rdy_val = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return a * 32'h9E37_79B1;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] bank_rd(input logic [31:0] a);
    return bank_mem.exists(a) ? bank_mem[a] : init_val(a);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    rsp_ready = rdy_force ? rdy_val : ($urandom_range(0, 3) != 0);
  end

  // Register-bank responder: valid data only in the sample cycle, garbage otherwise.
  logic        pend = 1'b0;
  int          ren_cyc = 0;
  logic [31:0] ren_addr = '0;
  always @(negedge clk) begin
    if (rst) pend = 1'b0;
    else if (io_ren) begin
      pend = 1'b1; ren_cyc = cyc; ren_addr = io_raddr;
    end
    if (pend && cyc > ren_cyc && cyc <= ren_cyc + LAT)
      check("raddr_stable", io_raddr, ren_addr);
    if (pend && cyc == ren_cyc + LAT) begin
      io_rdata = bank_rd(ren_addr);
      pend = 1'b0;
    end else begin
      io_rdata = $urandom;
    end
  end

  // Monitor: bus beats and responses against the scoreboard queues.
  logic        prev_valid = 1'b0, prev_ready = 1'b0, prev_wen = 1'b0, prev_ren = 1'b0;
  logic [33:0] held = '0;
  always @(negedge clk) begin
    wr_t  we;
    rd_t  re;
    rsp_t rs;
    if (rst) begin
      prev_valid = 1'b0; prev_ready = 1'b0; prev_wen = 1'b0; prev_ren = 1'b0;
    end else begin
      if (io_wen) begin
        check("wen_ren_excl", io_ren, 1'b0);
        check("wen_single", prev_wen, 1'b0);
        if (wr_q.size() == 0) check("wen_unexpected", 1'b1, 1'b0);
        else begin
          we = wr_q.pop_front();
          check("wen_cycle", cyc, we.exp_cyc);
          check("waddr", io_waddr, we.addr);
          check("wdata", io_wdata, we.data);
          check("wstrb", io_wstrb, we.strb);
          bank_mem[io_waddr] = merge(bank_rd(io_waddr), io_wdata, io_wstrb);
        end
      end
      if (io_ren) begin
        check("ren_single", prev_ren, 1'b0);
        if (rd_q.size() == 0) check("ren_unexpected", 1'b1, 1'b0);
        else begin
          re = rd_q.pop_front();
          check("ren_cycle", cyc, re.exp_cyc);
          check("raddr", io_raddr, re.addr);
        end
      end
      if (rsp_valid && !prev_valid) begin
        if (rsp_q.size() == 0) check("rsp_unexpected", 1'b1, 1'b0);
        else check("rsp_cycle", cyc, rsp_q[0].exp_cyc);
      end
      if (rsp_valid && prev_valid && !prev_ready)
        check("rsp_hold", {rsp_write, rsp_err, rsp_data}, held);
      if (rsp_valid && rsp_ready && rsp_q.size() != 0) begin
        rs = rsp_q.pop_front();
        check("rsp_write", rsp_write, rs.w);
        check("rsp_err", rsp_err, rs.err);
        check("rsp_data", rsp_data, rs.data);
        hs_cyc = cyc;
      end
      prev_valid = rsp_valid; prev_ready = rsp_ready;
      prev_wen = io_wen; prev_ren = io_ren;
      held = {rsp_write, rsp_err, rsp_data};
    end
  end

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    bit ok;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_data = d; cmd_strb = s;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check("cmd_accept_timeout", 1'b0, 1'b1);
    else begin
      acc_cyc = cyc;
      if (a[1:0] != 2'b00) begin
        rsp_q.push_back('{w: w, err: 1'b1, data: 32'h0, exp_cyc: acc_cyc + 1});
      end else if (w) begin
        wr_q.push_back('{addr: a, data: d, strb: s, exp_cyc: acc_cyc + 1});
        rsp_q.push_back('{w: 1'b1, err: 1'b0, data: 32'h0, exp_cyc: acc_cyc + 2});
        ref_mem[a] = merge(ref_rd(a), d, s);
      end else begin
        rd_q.push_back('{addr: a, exp_cyc: acc_cyc + 1});
        rsp_q.push_back('{w: 1'b0, err: 1'b0, data: ref_rd(a), exp_cyc: acc_cyc + 2 + LAT});
      end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (rsp_q.size() == 0 && wr_q.size() == 0 && rd_q.size() == 0 && !rsp_valid) begin
        ok = 1'b1; break;
      end
    end
    if (!ok) check("drain_timeout", 1'b0, 1'b1);
  endtask

  task automatic check_all_zero(input string name);
    check(name, {cmd_ready, rsp_valid, rsp_write, rsp_err, rsp_data, io_wen, io_ren,
                 io_waddr, io_wdata, io_wstrb, io_raddr}, '0);
  endtask

  initial begin
    logic [31:0] a, wa_before;
    bit ok;
    // Reset state.
    repeat (3) @(negedge clk);
    check_all_zero("reset_outputs");
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", cmd_ready, 1'b1);
    rdy_force = 1'b1; rdy_val = 1'b1;

    // Immediate-ready write, then reads of known data through the latency pipeline.
    issue(1'b1, 32'h8000_0000, 32'h0000_0001, 4'hF);
    issue(1'b1, 32'h8000_0004, 32'h0000_00A5, 4'hF);
    issue(1'b0, 32'h8000_0004, 32'h0, 4'h0);
    issue(1'b1, 32'h8000_0008, 32'h1234_5678, 4'hF);
    issue(1'b0, 32'h8000_0008, 32'h0, 4'h0);
    issue(1'b1, 32'h8000_0008, 32'hFFFF_FFFF, 4'b0101);
    issue(1'b0, 32'h8000_0008, 32'h0, 4'h0);
    drain();

    // Misaligned write: error response, no bus activity, write address untouched.
    @(negedge clk) wa_before = io_waddr;
    issue(1'b1, 32'h8000_0006, 32'hDEAD_BEEF, 4'hF);
    drain();
    check("misaligned_waddr_kept", io_waddr, wa_before);

    // Backpressure with a second command held on cmd_valid.
    rdy_val = 1'b0;
    issue(1'b1, 32'h8000_000C, 32'hCAFE_0001, 4'hF);
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1'b1; break; end
    end
    if (!ok) check("bp_rsp_timeout", 1'b0, 1'b1);
    fork
      issue(1'b0, 32'h8000_000C, 32'h0, 4'h0);
      begin
        repeat (5) begin
          @(negedge clk);
          check("bp_cmd_ready", cmd_ready, 1'b0);
          check("bp_no_strobe", {io_wen, io_ren}, 2'b00);
        end
        rdy_val = 1'b1;
      end
    join
    check("bp_accept_after_hs", acc_cyc, hs_cyc + 1);
    drain();

    // Reset in the middle of a read: the response is discarded.
    issue(1'b0, 32'h8000_0000, 32'h0, 4'h0);
    @(posedge clk); #1 rst = 1'b1;
    rsp_q.delete(); rd_q.delete(); wr_q.delete();
    @(posedge clk); #1;
    @(negedge clk);
    check_all_zero("midread_reset_outputs");
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("ready_after_midread_reset", cmd_ready, 1'b1);
    repeat (8) @(negedge clk);

    // Randomized traffic with random response backpressure.
    rdy_force = 1'b0;
    for (int i = 0; i < 60; i++) begin
      a = 32'h8000_0000 + 32'($urandom_range(0, 7)) * 4;
      if ($urandom_range(0, 4) == 0) a[1:0] = 2'($urandom_range(1, 3));
      issue(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
    end
    drain();
    check("queues_empty", rsp_q.size() + wr_q.size() + rd_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
